bitrev_pingpong: RTL

Double-buffered, parametrised bit-reversal reorder stage for the fixed-point FFT datapath. It accepts one N-point complex frame as N/LANES beats of LANES parallel samples in natural order. It emits the same frame in bit-reversed or natural order, selected per frame. Two banks are used in ping-pong, so frame k+1 is written while frame k is read out. Both sides use valid/ready handshakes for back-to-back frames without gaps.

---
 rtl/bitrev_pkg.sv | 35 +++
 rtl/bitrev_bank.sv | 55 +++++
 rtl/bitrev_pingpong.sv | 124 ++++++++++++
 3 files changed

// File: rtl/bitrev_pkg.sv
// Shared constants, sample type and bit-reverse helper for the bit-reversal
// reorder stage.
//   WIDTH_D / LANES_D / LOG2_N_D : default sample width, lanes per beat, log2(N)
//   sample_t                     : signed I/Q sample pair
//   bit_rev(idx, nbits)          : reverse the low nbits of idx (nbits <= 16)
package bitrev_pkg;

  localparam int WIDTH_D  = 13;
  localparam int LANES_D  = 16;
  localparam int LOG2_N_D = 9;
  localparam int REV_MAX  = 16;

  typedef struct packed {
    logic signed [WIDTH_D-1:0] i;
    logic signed [WIDTH_D-1:0] q;
  } sample_t;

  // Shift the low bits out LSB-first into the result, so idx[0] lands at
  // bit nbits-1. Loop bound is fixed so it unrolls to plain wiring.
  function automatic logic [REV_MAX-1:0] bit_rev(input logic [REV_MAX-1:0] idx,
                                                 input int nbits);
    logic [REV_MAX-1:0] r;
    logic [REV_MAX-1:0] tmp;
    r   = '0;
    tmp = idx;
    for (int b = 0; b < REV_MAX; b++) begin
      if (b < nbits) begin
        r   = {r[REV_MAX-2:0], tmp[0]};
        tmp = tmp >> 1;
      end
    end
    return r & ((REV_MAX'(1) << nbits) - REV_MAX'(1));
  endfunction

endpackage

// File: rtl/bitrev_bank.sv
// One N-deep I/Q sample bank.
//   clk      : clock
//   we       : write a full beat at row wr_row
//   wr_row   : beat index; lane c goes to address wr_row*LANES + c
//   wr_i/q   : LANES write samples
//   rd_addr  : LANES independent read addresses
//   rd_i/q   : combinational read data per lane
// Storage is split into LANES columns keyed by the address low bits, so each
// column takes exactly one write per beat; reads pick row, then column.
module bitrev_bank
  import bitrev_pkg::*;
#(
  parameter int WIDTH  = WIDTH_D,
  parameter int LANES  = LANES_D,
  parameter int LOG2_N = LOG2_N_D
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [LOG2_N-$clog2(LANES)-1:0] wr_row,
  input  logic signed [WIDTH-1:0]       wr_i    [LANES],
  input  logic signed [WIDTH-1:0]       wr_q    [LANES],
  input  logic [LOG2_N-1:0]             rd_addr [LANES],
  output logic signed [WIDTH-1:0]       rd_i    [LANES],
  output logic signed [WIDTH-1:0]       rd_q    [LANES]
);

  localparam int LW   = $clog2(LANES);
  localparam int ROWS = 1 << (LOG2_N - LW);

  logic signed [WIDTH-1:0] col_i [LANES][LANES];
  logic signed [WIDTH-1:0] col_q [LANES][LANES];

  for (genvar c = 0; c < LANES; c++) begin : g_col
    logic signed [WIDTH-1:0] mem_i [ROWS];
    logic signed [WIDTH-1:0] mem_q [ROWS];

    always_ff @(posedge clk) begin
      if (we) begin
        mem_i[wr_row] <= wr_i[c];
        mem_q[wr_row] <= wr_q[c];
      end
    end

    for (genvar r = 0; r < LANES; r++) begin : g_rd
      assign col_i[c][r] = mem_i[rd_addr[r][LOG2_N-1:LW]];
      assign col_q[c][r] = mem_q[rd_addr[r][LOG2_N-1:LW]];
    end
  end

  for (genvar r = 0; r < LANES; r++) begin : g_mux
    assign rd_i[r] = col_i[rd_addr[r][LW-1:0]][r];
    assign rd_q[r] = col_q[rd_addr[r][LW-1:0]][r];
  end

endmodule

// File: rtl/bitrev_pingpong.sv
// Double-buffered bit-reversal reorder stage.
//   clk, rstn          : clock, async active-low reset
//   din_valid/ready    : input beat handshake (ready from registered flags only)
//   din_i/q            : LANES input samples, natural order
//   bypass             : order for the frame, taken on its first beat (1 = natural)
//   do_en/do_ready     : output beat handshake
//   do_re/im, do_last  : output beat and end-of-frame marker
module bitrev_pingpong
  import bitrev_pkg::*;
#(
  parameter int WIDTH  = WIDTH_D,
  parameter int LANES  = LANES_D,
  parameter int LOG2_N = LOG2_N_D
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic signed [WIDTH-1:0] din_i [LANES],
  input  logic signed [WIDTH-1:0] din_q [LANES],
  input  logic                    bypass,
  output logic                    do_en,
  input  logic                    do_ready,
  output logic signed [WIDTH-1:0] do_re [LANES],
  output logic signed [WIDTH-1:0] do_im [LANES],
  output logic                    do_last
);

  localparam int LW = $clog2(LANES);
  localparam int CW = LOG2_N - LW;
  // B is a power of two, so the last beat index is all ones
  localparam logic [CW-1:0] LAST_BEAT = '1;

  logic [1:0]              full;
  logic [1:0]              mode;
  logic                    wr_sel, rd_sel;
  logic [CW-1:0]           wr_cnt, rd_cnt;
  logic                    wr_fire, rd_load, rd_mode;
  logic [LOG2_N-1:0]       rd_addr [LANES];
  logic signed [WIDTH-1:0] b0_i [LANES], b0_q [LANES];
  logic signed [WIDTH-1:0] b1_i [LANES], b1_q [LANES];

  assign din_ready = !full[wr_sel];
  assign wr_fire   = din_valid && din_ready;
  assign rd_load   = full[rd_sel] && (!do_en || do_ready);
  assign rd_mode   = mode[rd_sel];

  for (genvar g = 0; g < LANES; g++) begin : g_addr
    logic [LOG2_N-1:0]  lin;
    logic [REV_MAX-1:0] rev;
    assign lin        = {rd_cnt, LW'(g)};
    assign rev        = bit_rev(REV_MAX'(lin), LOG2_N);
    assign rd_addr[g] = rd_mode ? lin : rev[LOG2_N-1:0];
  end

  bitrev_bank #(.WIDTH(WIDTH), .LANES(LANES), .LOG2_N(LOG2_N)) u_bank0 (
    .clk(clk), .we(wr_fire && !wr_sel), .wr_row(wr_cnt),
    .wr_i(din_i), .wr_q(din_q), .rd_addr(rd_addr), .rd_i(b0_i), .rd_q(b0_q)
  );

  bitrev_bank #(.WIDTH(WIDTH), .LANES(LANES), .LOG2_N(LOG2_N)) u_bank1 (
    .clk(clk), .we(wr_fire && wr_sel), .wr_row(wr_cnt),
    .wr_i(din_i), .wr_q(din_q), .rd_addr(rd_addr), .rd_i(b1_i), .rd_q(b1_q)
  );

  // Write and read sides never touch the same bank on one edge: writing
  // needs the bank empty, reading needs it full.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full   <= '0;
      mode   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_cnt == '0) mode[wr_sel] <= bypass;
        if (wr_cnt == LAST_BEAT) begin
          full[wr_sel] <= 1'b1;
          wr_sel       <= !wr_sel;
          wr_cnt       <= '0;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      if (rd_load) begin
        if (rd_cnt == LAST_BEAT) begin
          full[rd_sel] <= 1'b0;
          rd_sel       <= !rd_sel;
          rd_cnt       <= '0;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      do_en   <= 1'b0;
      do_last <= 1'b0;
    end else if (rd_load) begin
      do_en   <= 1'b1;
      do_last <= (rd_cnt == LAST_BEAT);
    end else if (do_en && do_ready) begin
      do_en   <= 1'b0;
      do_last <= 1'b0;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_out
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        do_re[g] <= '0;
        do_im[g] <= '0;
      end else if (rd_load) begin
        do_re[g] <= rd_sel ? b1_i[g] : b0_i[g];
        do_im[g] <= rd_sel ? b1_q[g] : b0_q[g];
      end
    end
  end

endmodule
